line_buffer_window: RTL and testbench

Parametrised, valid-gated multi-line buffer for the image-processing datapath. It sits between the pixel stream source and the convolution window / MAC stage. Instead of one fixed 97-deep shift register, it stores NUM_LINES-1 previous lines in rotating RAM banks. Each cycle it emits one vertically aligned column of NUM_LINES pixels, with line length selectable at run time up to MAX_WIDTH.

---
 rtl/linebuf_pkg.sv | 15 +
 rtl/line_ram.sv | 31 +++
 rtl/line_buffer_window.sv | 138 +++++++++++++
 tb/tb_line_buffer_window.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared defaults and helpers for the multi-line pixel buffer.
package linebuf_pkg;

  localparam int LB_DATA_WIDTH = 14;
  localparam int LB_MAX_WIDTH  = 97;
  localparam int LB_NUM_LINES  = 3;
  localparam int LB_COL_W      = $clog2(LB_MAX_WIDTH);
  localparam int LB_BANK_W     =
    (LB_NUM_LINES > 2) ? $clog2(LB_NUM_LINES - 1) : 1;

  function automatic int clamp_len(input int len, input int max_w);
    return (len == 0 || len > max_w) ? max_w : len;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line bank: simple dual-port synchronous RAM, read-before-write.
module line_ram
  import linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int DEPTH      = LB_MAX_WIDTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; array contents stay stale.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_window.sv
// Rotating-bank line buffer emitting NUM_LINES-tall pixel columns.
// LINEBUF_OUTREG_EN adds one output register stage (latency 2).
module line_buffer_window
  import linebuf_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int MAX_WIDTH  = LB_MAX_WIDTH,
  parameter int NUM_LINES  = LB_NUM_LINES
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]  line_len,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic                            out_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] data_out,
  output logic [$clog2(MAX_WIDTH)-1:0]    out_col,
  output logic                            out_eol
);

  localparam int NB     = NUM_LINES - 1;
  localparam int COL_W  = $clog2(MAX_WIDTH);
  localparam int LEN_W  = $clog2(MAX_WIDTH + 1);
  localparam int BANK_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int LINE_W = $clog2(NUM_LINES);

  logic [COL_W-1:0]  col_q, col_e;
  logic [BANK_W-1:0] bank_q, bank_e, rbank_q;
  logic [LINE_W-1:0] line_q, line_e;
  logic [LEN_W-1:0]  len_q, len_e;
  logic              eol_e;

  logic [DATA_WIDTH-1:0]           tap0_q;
  logic [DATA_WIDTH-1:0]           rd [NB];
  logic [BANK_W-1:0]               sel;
  logic [NUM_LINES*DATA_WIDTH-1:0] taps;
  logic                            s1_valid, s1_eol;
  logic [COL_W-1:0]                s1_col;

  // Position of the pixel being accepted; sof overrides the counters.
  always_comb begin
    col_e  = col_q;
    bank_e = bank_q;
    line_e = line_q;
    len_e  = len_q;
    if (in_sof) begin
      col_e  = '0;
      bank_e = '0;
      line_e = '0;
      len_e  = LEN_W'(clamp_len(int'(line_len), MAX_WIDTH));
    end
    eol_e = (int'(col_e) == int'(len_e) - 1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_q    <= '0;
      bank_q   <= '0;
      line_q   <= '0;
      len_q    <= LEN_W'(MAX_WIDTH);
      tap0_q   <= '0;
      rbank_q  <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_eol   <= 1'b0;
    end else if (in_valid) begin
      len_q <= len_e;
      if (eol_e) begin
        col_q  <= '0;
        bank_q <= (int'(bank_e) == NB - 1) ? '0
                : bank_e + BANK_W'(1);
        line_q <= (int'(line_e) == NUM_LINES - 1) ? line_e
                : line_e + LINE_W'(1);
      end else begin
        col_q  <= col_e + COL_W'(1);
        bank_q <= bank_e;
        line_q <= line_e;
      end
      tap0_q   <= data_in;
      rbank_q  <= bank_e;
      s1_valid <= (int'(line_e) == NUM_LINES - 1);
      s1_col   <= col_e;
      s1_eol   <= eol_e;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_WIDTH)
    ) u_ram (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (in_valid && (bank_e == BANK_W'(b))),
      .waddr (col_e),
      .wdata (data_in),
      .re    (in_valid),
      .raddr (col_e),
      .rdata (rd[b])
    );
  end

  // Tap k lives in the bank written k lines before the current one.
  always_comb begin
    taps = '0;
    sel  = '0;
    taps[DATA_WIDTH-1:0] = tap0_q;
    for (int k = 1; k < NUM_LINES; k++) begin
      sel = BANK_W'((int'(rbank_q) + NB - (k % NB)) % NB);
      taps[k*DATA_WIDTH +: DATA_WIDTH] = rd[sel];
    end
  end

`ifdef LINEBUF_OUTREG_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_col   <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      data_out  <= taps;
      out_col   <= s1_col;
      out_eol   <= s1_eol;
    end
  end
`else
  assign out_valid = s1_valid;
  assign data_out  = taps;
  assign out_col   = s1_col;
  assign out_eol   = s1_eol;
`endif

endmodule

// File: tb/tb_line_buffer_window.sv
// Scoreboard bench for line_buffer_window (3 taps, 14-bit, 97 wide).
module tb_line_buffer_window;

  localparam int DW = 14;
  localparam int MW = 97;
  localparam int NL = 3;
  localparam int LW = $clog2(MW + 1);
  localparam int CW = $clog2(MW);
`ifdef LINEBUF_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [NL*DW-1:0] data;
    logic [CW-1:0]    col;
    logic             eol;
    int               cyc;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [LW-1:0]    line_len = '0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [DW-1:0]    data_in = '0;
  logic             out_valid;
  logic [NL*DW-1:0] data_out;
  logic [CW-1:0]    out_col;
  logic             out_eol;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_out = 0;
  logic [DW-1:0] hist [3][MW];
  int mrow = 0, mcol = 0, mlen = MW;

  line_buffer_window dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .line_len  (line_len),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_col   (out_col),
    .out_eol   (out_eol)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  // Scoreboard: every emitted column must match the head of the queue.
  always @(negedge Clk) begin
    if (!Rst && out_valid) begin
      exp_t e;
      n_out++;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_col: out_valid at cyc %0d data %h col %0d, required no output",
                 cyc, data_out, out_col);
      end else begin
        e = q.pop_front();
        if (data_out !== e.data || out_col !== e.col ||
            out_eol !== e.eol || cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL column: got data %h col %0d eol %b cyc %0d, required data %h col %0d eol %b cyc %0d",
                   data_out, out_col, out_eol, cyc, e.data, e.col, e.eol, e.cyc);
        end
      end
    end
  end

  task automatic model_reset();
    mrow = 0;
    mcol = 0;
    mlen = MW;
    q.delete();
  endtask

  task automatic px(input logic [DW-1:0] pix, input logic sof, input int len);
    exp_t e;
    in_valid = 1'b1;
    in_sof   = sof;
    line_len = LW'(len);
    data_in  = pix;
    if (sof) begin
      mrow = 0;
      mcol = 0;
      mlen = (len == 0 || len > MW) ? MW : len;
    end
    hist[mrow % 3][mcol] = pix;
    if (mrow >= 2) begin
      e.data = {hist[(mrow - 2) % 3][mcol], hist[(mrow - 1) % 3][mcol], pix};
      e.col  = CW'(mcol);
      e.eol  = (mcol == mlen - 1);
      e.cyc  = cyc + LAT;
      q.push_back(e);
    end
    if (mcol == mlen - 1) begin
      mcol = 0;
      mrow++;
    end else begin
      mcol++;
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b required 0", out_valid);
    end
    vectors++;
    if (data_out !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", data_out);
    end
    vectors++;
    if (out_col !== '0 || out_eol !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_col_eol: got col %0d eol %b required 0 0", out_col, out_eol);
    end
    Rst = 1'b0;
    model_reset();
    idle(1);
  endtask

  task automatic test_basic();
    int n0 = n_out;
    for (int i = 0; i < 12; i++) px(DW'(i), i == 0, 4);
    idle(LAT + 2);
    vectors++;
    if (q.size() != 0 || n_out - n0 != 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d columns (%0d pending) required 4",
               n_out - n0, q.size());
    end
  endtask

  task automatic test_gapped();
    int n0 = n_out;
    for (int i = 0; i < 12; i++) begin
      px(DW'(i), i == 0, 4);
      idle(1);
    end
    idle(LAT + 2);
    vectors++;
    if (q.size() != 0 || n_out - n0 != 4) begin
      miscompares++;
      $display("FAIL gapped_count: got %0d columns (%0d pending) required 4",
               n_out - n0, q.size());
    end
  endtask

  task automatic test_wrap_sof();
    int n0 = n_out;
    for (int i = 0; i < 16; i++) px(DW'(i), i == 0, 4);
    for (int i = 16; i < 28; i++) px(DW'(i), i == 16, 4);
    idle(LAT + 2);
    vectors++;
    if (q.size() != 0 || n_out - n0 != 12) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d columns (%0d pending) required 12",
               n_out - n0, q.size());
    end
  endtask

  task automatic test_clamp(input int len);
    int n0 = n_out;
    for (int i = 0; i < 3 * MW; i++)
      px(DW'($urandom), i == 0, len);
    idle(LAT + 2);
    vectors++;
    if (q.size() != 0 || n_out - n0 != MW) begin
      miscompares++;
      $display("FAIL clamp_%0d: got %0d columns (%0d pending) required %0d",
               len, n_out - n0, q.size(), MW);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    for (int i = 0; i < 10; i++) px(DW'(100 + i), i == 0, 4);
    Rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || data_out !== '0) begin
      miscompares++;
      $display("FAIL midreset_out: got valid %b data %h required 0 0",
               out_valid, data_out);
    end
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 3 * MW; i++) px(DW'($urandom), 1'b0, 0);
    idle(LAT + 2);
    vectors++;
    if (q.size() != 0 || n_out - n0 != MW) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d columns (%0d pending) required %0d",
               n_out - n0, q.size(), MW);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_wrap_sof();
    test_clamp(0);
    test_clamp(MW + 5);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
